// File: rtl/usbfs_endp_tx_pkt.sv
// USB FS IN-endpoint packetiser: buffers a byte stream into packets and holds each until ACKed.
// Define USBFS_ENDP_TX_ZLP_EN to append a zero-length packet after a full final packet.
module usbfs_endp_tx_pkt #(
   parameter int MAX_PKT = 8,
   parameter int IDX_W   = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1,
   parameter int NB_W    = $clog2(MAX_PKT + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic             o_ready,
   input  logic             i_valid,
   input  logic [7:0]       i_data,
   input  logic             i_last,
   input  logic             i_inToken,
   input  logic             i_txStart,
   input  logic             i_ack,
   input  logic             i_txFail,
   input  logic             i_clrToggle,
   input  logic             i_halt,
   output logic             o_pktValid,
   output logic [NB_W-1:0]  o_pktNBytes,
   output logic             o_pktPid1,
   input  logic [IDX_W-1:0] i_rdIdx,
   output logic [7:0]       o_rdByte,
   output logic             o_stall
);

`ifdef USBFS_ENDP_TX_ZLP_EN
   localparam bit ZLP_EN = 1'b1;
`else
   localparam bit ZLP_EN = 1'b0;
`endif
   localparam logic [NB_W-1:0] MAX_CNT = NB_W'(MAX_PKT);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_HOLD = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t          r_state, w_stateNxt;
   logic [NB_W-1:0] r_count, w_countNxt, w_countInc;
   logic            r_pid1, w_pid1Nxt;
   logic            r_zlp, w_zlpNxt;
   logic            r_stall;
   logic [7:0]      r_buf [MAX_PKT];
   logic [7:0]      r_rdByte;
   logic            w_accept, w_full, w_haltRel;

   assign w_accept   = (r_state == S_FILL) && i_valid;
   assign w_countInc = r_count + NB_W'(1);
   assign w_full     = (w_countInc == MAX_CNT);
   assign w_haltRel  = r_stall && !i_halt;

   always_comb begin
      w_stateNxt = r_state;
      w_countNxt = r_count;
      w_pid1Nxt  = r_pid1;
      w_zlpNxt   = r_zlp;
      unique case (r_state)
         S_FILL: begin
            if (w_accept) begin
               w_countNxt = w_countInc;
               if (w_full || i_last || i_inToken) w_stateNxt = S_HOLD;
               if (ZLP_EN && w_full && i_last)   w_zlpNxt   = 1'b1;
            end else if (i_inToken && (r_count != '0)) begin
               w_stateNxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_txStart && !r_stall) w_stateNxt = S_SEND;
         end
         S_SEND: begin
            if (i_ack) begin
               // A pending ZLP is sent as an empty held packet with the toggled PID
               w_countNxt = '0;
               w_pid1Nxt  = !r_pid1;
               w_zlpNxt   = 1'b0;
               w_stateNxt = r_zlp ? S_HOLD : S_FILL;
            end else if (i_txFail) begin
               w_stateNxt = S_HOLD;
            end
         end
         default: w_stateNxt = S_FILL;
      endcase
      if (i_clrToggle || w_haltRel) w_pid1Nxt = 1'b0;
      if (w_haltRel)                w_zlpNxt  = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_FILL;
         r_count <= '0;
         r_pid1  <= 1'b0;
         r_zlp   <= 1'b0;
         r_stall <= 1'b0;
      end else begin
         r_state <= w_stateNxt;
         r_count <= w_countNxt;
         r_pid1  <= w_pid1Nxt;
         r_zlp   <= w_zlpNxt;
         r_stall <= i_halt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < unsigned'(MAX_PKT); i++) r_buf[i] <= '0;
         r_rdByte <= '0;
      end else begin
         if (w_accept) r_buf[r_count[IDX_W-1:0]] <= i_data;
         r_rdByte <= (32'(i_rdIdx) < 32'(MAX_PKT)) ? r_buf[i_rdIdx] : '0;
      end
   end

   assign o_ready     = (r_state == S_FILL);
   assign o_pktValid  = (r_state != S_FILL) && !r_stall;
   assign o_pktNBytes = r_count;
   assign o_pktPid1   = r_pid1;
   assign o_rdByte    = r_rdByte;
   assign o_stall     = r_stall;

endmodule

// File: tb/tb_usbfs_endp_tx_pkt.sv
// Bench for usbfs_endp_tx_pkt: directed vector table, ZLP sequence, randomized run against a packet-level model.
module tb_usbfs_endp_tx_pkt;
   localparam int MAX_PKT = 8;
   localparam int IDX_W   = 3;
   localparam int NB_W    = 4;
`ifdef USBFS_ENDP_TX_ZLP_EN
   localparam bit ZLP = 1'b1;
`else
   localparam bit ZLP = 1'b0;
`endif

   // control word bits: {rst,valid,last,inTok,txStart,ack,txFail,clr,halt}
   localparam logic [8:0] R = 9'h100, V = 9'h080, L = 9'h040, T = 9'h020, S = 9'h010,
                          A = 9'h008, F = 9'h004, C = 9'h002, H = 9'h001, N = 9'h000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, valid = 1'b0, last = 1'b0, inTok = 1'b0, txStart = 1'b0;
   logic ack = 1'b0, txFail = 1'b0, clr = 1'b0, halt = 1'b0;
   logic [7:0] data = '0;
   logic [IDX_W-1:0] rdIdx = '0;
   logic ready, pktValid, pid1, stall;
   logic [NB_W-1:0] nb;
   logic [7:0] rdByte;

   int n_cmp = 0;
   int n_bad = 0;

   usbfs_endp_tx_pkt #(.MAX_PKT(MAX_PKT)) dut (
      .i_clk(clk), .i_rst(rst), .o_ready(ready), .i_valid(valid), .i_data(data),
      .i_last(last), .i_inToken(inTok), .i_txStart(txStart), .i_ack(ack),
      .i_txFail(txFail), .i_clrToggle(clr), .i_halt(halt), .o_pktValid(pktValid),
      .o_pktNBytes(nb), .o_pktPid1(pid1), .i_rdIdx(rdIdx), .o_rdByte(rdByte),
      .o_stall(stall)
   );

   typedef struct {
      logic [8:0]       ctl;
      logic [7:0]       d;
      logic [IDX_W-1:0] idx;
      logic             e_rdy, e_vld;
      logic [NB_W-1:0]  e_nb;
      logic             e_pid, e_st;
      logic [7:0]       e_rd;
   } vec_t;

   function automatic vec_t mk(input logic [8:0] c, input logic [7:0] d, input logic [IDX_W-1:0] ix,
                               input logic rdy, vld, input logic [NB_W-1:0] n,
                               input logic p, st, input logic [7:0] rd);
      vec_t x;
      x.ctl = c; x.d = d; x.idx = ix; x.e_rdy = rdy; x.e_vld = vld;
      x.e_nb = n; x.e_pid = p; x.e_st = st; x.e_rd = rd;
      return x;
   endfunction

   // Packet-level reference: current packet length, whether it is closed, whether it is on the wire
   int m_len = 0;
   bit m_held = 0, m_inflight = 0, m_pid = 0, m_zlp = 0, m_stall = 0;
   int m_mem [MAX_PKT];
   int m_rd = 0;

   task automatic model_step();
      int rd;
      rd = (int'(rdIdx) < MAX_PKT) ? m_mem[rdIdx] : 0;
      if (rst) begin
         m_len = 0; m_held = 0; m_inflight = 0; m_pid = 0; m_zlp = 0; m_stall = 0;
         foreach (m_mem[i]) m_mem[i] = 0;
         m_rd = 0;
         return;
      end
      if (!m_held && valid) begin
         m_mem[m_len] = int'(data);
         m_len++;
         if (m_len == MAX_PKT || last || inTok) begin
            m_held = 1;
            if (ZLP && last && m_len == MAX_PKT) m_zlp = 1;
         end
      end else if (!m_held && inTok && m_len > 0) begin
         m_held = 1;
      end else if (m_held && !m_inflight && txStart && !m_stall) begin
         m_inflight = 1;
      end else if (m_inflight && ack) begin
         m_pid = !m_pid;
         m_len = 0;
         m_inflight = 0;
         if (m_zlp) m_zlp = 0;
         else       m_held = 0;
      end else if (m_inflight && txFail) begin
         m_inflight = 0;
      end
      if (clr || (m_stall && !halt)) m_pid = 0;
      if (m_stall && !halt) m_zlp = 0;
      m_stall = halt;
      m_rd = rd;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic [8:0] c, input logic [7:0] d, input logic [IDX_W-1:0] ix);
      {rst, valid, last, inTok, txStart, ack, txFail, clr, halt} = c;
      data  = d;
      rdIdx = ix;
   endtask

   task automatic tick(input bit use_model);
      model_step();
      @(posedge clk);
      #1;
      if (use_model) begin
         chk("rnd_ready", 32'(ready),    32'(!m_held));
         chk("rnd_valid", 32'(pktValid), 32'(m_held && !m_stall));
         chk("rnd_nbytes", 32'(nb),      32'(m_len));
         chk("rnd_pid",   32'(pid1),     32'(m_pid));
         chk("rnd_stall", 32'(stall),    32'(m_stall));
         chk("rnd_rdbyte", 32'(rdByte),  32'(m_rd));
      end
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back(mk(R, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(mk(V, 8'(8'h10 + k - 1), 0, k < 8, k == 8, 4'(k), 0, 0, (k == 1) ? 8'h00 : 8'h10));
      tbl.push_back(mk(N,     8'h00, 3, 0, 1, 8, 0, 0, 8'h13));
      tbl.push_back(mk(S,     8'h00, 3, 0, 1, 8, 0, 0, 8'h13));
      tbl.push_back(mk(F,     8'h00, 3, 0, 1, 8, 0, 0, 8'h13));
      tbl.push_back(mk(S,     8'h00, 3, 0, 1, 8, 0, 0, 8'h13));
      tbl.push_back(mk(A,     8'h00, 3, 1, 0, 0, 1, 0, 8'h13));
      tbl.push_back(mk(V,     8'hA0, 1, 1, 0, 1, 1, 0, 8'h11));
      tbl.push_back(mk(V,     8'hA1, 1, 1, 0, 2, 1, 0, 8'h11));
      tbl.push_back(mk(V,     8'hA2, 1, 1, 0, 3, 1, 0, 8'hA1));
      tbl.push_back(mk(N,     8'h00, 1, 1, 0, 3, 1, 0, 8'hA1));
      tbl.push_back(mk(T,     8'h00, 1, 0, 1, 3, 1, 0, 8'hA1));
      tbl.push_back(mk(H,     8'h00, 2, 0, 0, 3, 1, 1, 8'hA2));
      tbl.push_back(mk(H | S, 8'h00, 2, 0, 0, 3, 1, 1, 8'hA2));
      tbl.push_back(mk(N,     8'h00, 2, 0, 1, 3, 0, 0, 8'hA2));
      tbl.push_back(mk(A,     8'h00, 2, 0, 1, 3, 0, 0, 8'hA2));
      tbl.push_back(mk(S,     8'h00, 2, 0, 1, 3, 0, 0, 8'hA2));
      tbl.push_back(mk(A | F, 8'h00, 2, 1, 0, 0, 1, 0, 8'hA2));
      tbl.push_back(mk(V | L, 8'h77, 2, 0, 1, 1, 1, 0, 8'hA2));
      tbl.push_back(mk(S,     8'h00, 2, 0, 1, 1, 1, 0, 8'hA2));
      tbl.push_back(mk(A | C, 8'h00, 2, 1, 0, 0, 0, 0, 8'hA2));
      tbl.push_back(mk(T,     8'h00, 2, 1, 0, 0, 0, 0, 8'hA2));
      tbl.push_back(mk(V | L, 8'h01, 2, 0, 1, 1, 0, 0, 8'hA2));
      tbl.push_back(mk(S,     8'h00, 2, 0, 1, 1, 0, 0, 8'hA2));
      tbl.push_back(mk(R,     8'h00, 2, 1, 0, 0, 0, 0, 8'h00));

      foreach (tbl[i]) begin
         apply(tbl[i].ctl, tbl[i].d, tbl[i].idx);
         tick(0);
         chk($sformatf("t%0d_ready", i),  32'(ready),    32'(tbl[i].e_rdy));
         chk($sformatf("t%0d_valid", i),  32'(pktValid), 32'(tbl[i].e_vld));
         chk($sformatf("t%0d_nbytes", i), 32'(nb),       32'(tbl[i].e_nb));
         chk($sformatf("t%0d_pid", i),    32'(pid1),     32'(tbl[i].e_pid));
         chk($sformatf("t%0d_stall", i),  32'(stall),    32'(tbl[i].e_st));
         chk($sformatf("t%0d_rdbyte", i), 32'(rdByte),   32'(tbl[i].e_rd));
      end

      // Full packet terminated by i_last, then ACK: ZLP follows only when the feature is built in
      for (int k = 0; k < 8; k++) begin
         apply(V | ((k == 7) ? L : N), 8'(k), 0);
         tick(0);
      end
      chk("zlp_full_valid", 32'(pktValid), 32'd1);
      chk("zlp_full_nb",    32'(nb),       32'd8);
      apply(S, 0, 0); tick(0);
      apply(A, 0, 0); tick(0);
      chk("zlp_ack_pid",  32'(pid1),     32'd1);
      chk("zlp_ack_nb",   32'(nb),       32'd0);
      chk("zlp_ack_valid", 32'(pktValid), 32'(ZLP));
      chk("zlp_ack_ready", 32'(ready),    32'(!ZLP));
      if (ZLP) begin
         apply(S, 0, 0); tick(0);
         apply(F, 0, 0); tick(0);
         chk("zlp_retx_valid", 32'(pktValid), 32'd1);
         chk("zlp_retx_pid",   32'(pid1),     32'd1);
         apply(S, 0, 0); tick(0);
         apply(A, 0, 0); tick(0);
         chk("zlp_done_ready", 32'(ready), 32'd1);
         chk("zlp_done_pid",   32'(pid1),  32'd0);
      end

      apply(R, 0, 0);
      tick(1);
      for (int c = 0; c < 4000; c++) begin
         logic [8:0] ctl;
         logic h;
         h = halt;
         if ($urandom_range(0, 29) == 0) h = !h;
         ctl = N;
         if ($urandom_range(0, 399) == 0)          ctl |= R;
         if ($urandom_range(0, 1) == 0)            ctl |= V;
         if ($urandom_range(0, 7) == 0)            ctl |= L;
         if ($urandom_range(0, 7) == 0)            ctl |= T;
         if ($urandom_range(0, 3) == 0)            ctl |= S;
         if ($urandom_range(0, 3) == 0)            ctl |= A;
         if ($urandom_range(0, 5) == 0)            ctl |= F;
         if (!m_inflight && $urandom_range(0, 19) == 0) ctl |= C;
         if (h)                                    ctl |= H;
         apply(ctl, 8'($urandom), IDX_W'($urandom));
         tick(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
